// File: rtl/opo_package.sv
// Shared types and helpers for the LIA filter-path control blocks.
//   word_width       : sample width on the filter / downstream path
//   max_stages       : widest stage_enable vector any sequencer may drive
//   cfg_width        : width of the requested stage count
//   lpf_seq_state_t  : low-pass filter stage sequencer states
//   thermometer_mask : ones in bits [count-1:0], limited to 'width' bits
package opo_package;

    localparam int unsigned word_width = 16;
    localparam int unsigned max_stages = 16;
    localparam int unsigned cfg_width  = 5;

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        APPLY  = 2'd1,
        SETTLE = 2'd2
    } lpf_seq_state_t;

    function automatic logic [max_stages-1:0] thermometer_mask(
        input logic [cfg_width-1:0] count,
        input int unsigned          width
    );
        logic [max_stages-1:0] mask;
        mask = '0;
        for (int unsigned i = 0; i < max_stages; i++) begin
            mask[i] = (i < width) && (i < 32'(count));
        end
        return mask;
    endfunction

endpackage

// File: rtl/lpf_stage_sequencer_if.sv
// Bus between the stage sequencer, the register bank, the filter chain
// and the downstream PID / lock logic.
//   cfg_stages/cfg_valid       : stage-count request from the register bank
//   stage_enable               : thermometer enable mask to the filter chain
//   filt_sample/filt_valid     : filter chain output
//   sample_out/sample_out_valid: gated, held sample to downstream
//   settled                    : high while the chain output is trusted
//   cfg_clamped                : sticky flag, a request exceeded num_stages
interface lpf_stage_sequencer_if
    import opo_package::*;
#(
    parameter int unsigned num_stages = 8
) ();

    logic [cfg_width-1:0]  cfg_stages;
    logic                  cfg_valid;
    logic [num_stages-1:0] stage_enable;
    logic [word_width-1:0] filt_sample;
    logic                  filt_valid;
    logic [word_width-1:0] sample_out;
    logic                  sample_out_valid;
    logic                  settled;
    logic                  cfg_clamped;

    modport master (
        output cfg_stages, cfg_valid, filt_sample, filt_valid,
        input  stage_enable, sample_out, sample_out_valid, settled, cfg_clamped
    );

    modport slave (
        input  cfg_stages, cfg_valid, filt_sample, filt_valid,
        output stage_enable, sample_out, sample_out_valid, settled, cfg_clamped
    );

endinterface

// File: rtl/lpf_stage_sequencer.sv
// Sequences the stage_enable mask of the cascaded low-pass filter chain and
// blanks the chain output while it refills after every change.
//   clk : system clock
//   rst : synchronous, active-high reset
//   bus : lpf_stage_sequencer_if slave (config in, mask out, filter in,
//         gated sample out, status)
module lpf_stage_sequencer
    import opo_package::*;
#(
    parameter int unsigned num_stages       = 8,
    parameter int unsigned settle_per_stage = 2,
    parameter int unsigned cnt_width        = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    lpf_stage_sequencer_if.slave   bus
);

    lpf_seq_state_t        state_q,   state_d;
    logic [cfg_width-1:0]  target_q,  target_d;
    logic [cfg_width-1:0]  applied_q, applied_d;
    logic [num_stages-1:0] mask_q,    mask_d;
    logic [cnt_width-1:0]  cnt_q,     cnt_d;
    logic [word_width-1:0] sample_q,  sample_d;
    logic                  valid_q,   valid_d;
    logic                  settled_q, settled_d;
    logic                  clamped_q, clamped_d;

    logic                  req_over;
    logic [cfg_width-1:0]  req_target;
    logic [cnt_width-1:0]  settle_load;

    // An empty chain still needs one stage's worth of strobes to flush.
    assign settle_load = cnt_width'(((target_q == '0) ? 32'd1 : 32'(target_q)) * settle_per_stage);

    // State register and all registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= RUN;
            target_q  <= '0;
            applied_q <= '0;
            mask_q    <= '0;
            cnt_q     <= '0;
            sample_q  <= '0;
            valid_q   <= 1'b0;
            settled_q <= 1'b1;
            clamped_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            target_q  <= target_d;
            applied_q <= applied_d;
            mask_q    <= mask_d;
            cnt_q     <= cnt_d;
            sample_q  <= sample_d;
            valid_q   <= valid_d;
            settled_q <= settled_d;
            clamped_q <= clamped_d;
        end
    end

    // Next-state, mask, counter and sample gating.
    always_comb begin
        state_d    = state_q;
        target_d   = target_q;
        applied_d  = applied_q;
        mask_d     = mask_q;
        cnt_d      = cnt_q;
        sample_d   = sample_q;
        valid_d    = 1'b0;
        clamped_d  = clamped_q;
        req_over   = bus.cfg_stages > cfg_width'(num_stages);
        req_target = req_over ? cfg_width'(num_stages) : bus.cfg_stages;

        if (bus.cfg_valid && req_over) begin
            clamped_d = 1'b1;
        end

        unique case (state_q)
            RUN: begin
                // A request matching the applied count leaves the chain alone.
                if (bus.cfg_valid && (req_target != applied_q)) begin
                    target_d = req_target;
                    state_d  = APPLY;
                end
                if (bus.filt_valid) begin
                    sample_d = bus.filt_sample;
                    valid_d  = 1'b1;
                end
            end
            APPLY: begin
                if (bus.cfg_valid) begin
                    target_d = req_target;
                end else begin
                    mask_d    = num_stages'(thermometer_mask(target_q, num_stages));
                    applied_d = target_q;
                    cnt_d     = settle_load;
                    state_d   = SETTLE;
                end
            end
            SETTLE: begin
                // A new request outranks the final settle strobe.
                if (bus.cfg_valid) begin
                    target_d = req_target;
                    state_d  = APPLY;
                end else if (bus.filt_valid) begin
                    cnt_d = cnt_q - cnt_width'(1);
                    if (cnt_q == cnt_width'(1)) begin
                        state_d = RUN;
                    end
                end
            end
            default: begin
                state_d = RUN;
            end
        endcase

        settled_d = (state_d == RUN);
    end

    assign bus.stage_enable     = mask_q;
    assign bus.sample_out       = sample_q;
    assign bus.sample_out_valid = valid_q;
    assign bus.settled          = settled_q;
    assign bus.cfg_clamped      = clamped_q;

    // The counter is loaded non-zero and leaves SETTLE on reaching one.
    settle_no_underflow: assert property (
        @(posedge clk) disable iff (rst)
        (state_q == SETTLE && bus.filt_valid) |-> (cnt_q != '0)
    );

endmodule

// File: tb/tb_lpf_stage_sequencer.sv
// Self-checking bench for lpf_stage_sequencer: directed scenarios followed
// by randomized traffic, all checked cycle by cycle against a behavioural
// model of the blanking window.
module tb_lpf_stage_sequencer;
    import opo_package::*;

    localparam int unsigned num_stages = 8;
    localparam int unsigned settle_per_stage = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    lpf_stage_sequencer_if #(.num_stages(num_stages)) bus ();

    lpf_stage_sequencer #(
        .num_stages       (num_stages),
        .settle_per_stage (settle_per_stage),
        .cnt_width        (8)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Behavioural model: outputs expected after the coming edge.
    logic [7:0]  m_mask    = '0;
    int          m_applied = 0;
    logic        m_settled = 1'b1;
    logic [15:0] m_out     = '0;
    logic        m_valid   = 1'b0;
    logic        m_clamp   = 1'b0;
    logic        m_pending = 1'b0;
    int          m_tgt     = 0;
    int          m_left    = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_step();
        int t;
        if (rst) begin
            m_mask = '0; m_applied = 0; m_settled = 1'b1; m_out = '0;
            m_valid = 1'b0; m_clamp = 1'b0; m_pending = 1'b0; m_tgt = 0; m_left = 0;
            return;
        end
        t = (int'(bus.cfg_stages) > int'(num_stages)) ? int'(num_stages) : int'(bus.cfg_stages);
        m_valid = 1'b0;
        if (bus.cfg_valid && t != int'(bus.cfg_stages)) m_clamp = 1'b1;
        if (m_settled && bus.filt_valid) begin
            m_out   = bus.filt_sample;
            m_valid = 1'b1;
        end
        if (bus.cfg_valid && !(m_settled && t == m_applied)) begin
            m_pending = 1'b1;
            m_tgt     = t;
            m_settled = 1'b0;
        end else if (m_pending) begin
            m_pending = 1'b0;
            m_applied = m_tgt;
            m_mask    = 8'((1 << m_tgt) - 1);
            m_left    = ((m_tgt == 0) ? 1 : m_tgt) * int'(settle_per_stage);
        end else if (!m_settled && bus.filt_valid) begin
            m_left--;
            if (m_left == 0) m_settled = 1'b1;
        end
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
        chk("stage_enable",     32'(bus.stage_enable),     32'(m_mask));
        chk("settled",          32'(bus.settled),          32'(m_settled));
        chk("sample_out",       32'(bus.sample_out),       32'(m_out));
        chk("sample_out_valid", 32'(bus.sample_out_valid), 32'(m_valid));
        chk("cfg_clamped",      32'(bus.cfg_clamped),      32'(m_clamp));
    endtask

    task automatic pulse(input logic [15:0] s, output logic fwd);
        bus.filt_valid  = 1'b1;
        bus.filt_sample = s;
        tick();
        fwd = bus.sample_out_valid;
        bus.filt_valid = 1'b0;
        tick();
    endtask

    task automatic cfg(input logic [4:0] n);
        bus.cfg_valid  = 1'b1;
        bus.cfg_stages = n;
        tick();
        bus.cfg_valid = 1'b0;
    endtask

    initial begin
        logic fwd;
        bus.cfg_valid   = 1'b0;
        bus.cfg_stages  = '0;
        bus.filt_valid  = 1'b0;
        bus.filt_sample = '0;

        // Reset state, then a plain forwarded sample.
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        chk("rst_mask",    32'(bus.stage_enable), 32'h00);
        chk("rst_settled", 32'(bus.settled),      32'h1);
        chk("rst_sample",  32'(bus.sample_out),   32'h0);
        bus.filt_valid  = 1'b1;
        bus.filt_sample = 16'h1234;
        tick();
        chk("first_fwd_valid", 32'(bus.sample_out_valid), 32'h1);
        chk("first_fwd_data",  32'(bus.sample_out),       32'h1234);
        bus.filt_valid = 1'b0;
        tick();
        chk("first_fwd_one_cycle", 32'(bus.sample_out_valid), 32'h0);

        // Three stages: mask two cycles after the strobe, six strobes dropped.
        cfg(5'd3);
        chk("cfg3_settled_low", 32'(bus.settled),      32'h0);
        chk("cfg3_mask_wait",   32'(bus.stage_enable), 32'h00);
        tick();
        chk("cfg3_mask", 32'(bus.stage_enable), 32'h07);
        for (int i = 1; i <= 7; i++) begin
            pulse(16'h1000 + 16'(i), fwd);
            if (i < 7) begin
                chk("cfg3_drop", 32'(fwd), 32'h0);
                chk("cfg3_held", 32'(bus.sample_out), 32'h1234);
            end else begin
                chk("cfg3_fwd7",  32'(fwd), 32'h1);
                chk("cfg3_data7", 32'(bus.sample_out), 32'h1007);
            end
            if (i == 6) chk("cfg3_settled_after6", 32'(bus.settled), 32'h1);
        end

        // Same count again: no blanking.
        cfg(5'd3);
        chk("same_cfg_settled", 32'(bus.settled), 32'h1);
        pulse(16'hBEEF, fwd);
        chk("same_cfg_fwd", 32'(fwd), 32'h1);

        // Over-range request clamps to all stages, 16-strobe window.
        cfg(5'd20);
        chk("clamp_flag", 32'(bus.cfg_clamped), 32'h1);
        tick();
        chk("clamp_mask", 32'(bus.stage_enable), 32'hFF);
        for (int i = 1; i <= 17; i++) begin
            pulse(16'h2000 + 16'(i), fwd);
            chk("clamp_window", 32'(fwd), (i == 17) ? 32'h1 : 32'h0);
        end
        cfg(5'd4);
        tick();
        chk("clamp_sticky", 32'(bus.cfg_clamped), 32'h1);
        for (int i = 1; i <= 8; i++) pulse(16'h2100 + 16'(i), fwd);

        // Restart mid-settle: counter reloads for the new target.
        cfg(5'd2);
        tick();
        pulse(16'h3001, fwd);
        pulse(16'h3002, fwd);
        cfg(5'd5);
        tick();
        chk("restart_mask", 32'(bus.stage_enable), 32'h1F);
        for (int i = 1; i <= 11; i++) begin
            pulse(16'h3100 + 16'(i), fwd);
            chk("restart_window", 32'(fwd), (i == 11) ? 32'h1 : 32'h0);
        end

        // Reset during settling.
        cfg(5'd4);
        tick();
        for (int i = 1; i <= 3; i++) pulse(16'h4000 + 16'(i), fwd);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("midrst_mask",    32'(bus.stage_enable), 32'h00);
        chk("midrst_settled", 32'(bus.settled),      32'h1);
        chk("midrst_sample",  32'(bus.sample_out),   32'h0);
        chk("midrst_clamp",   32'(bus.cfg_clamped),  32'h0);

        // New config coinciding with the final settle strobe wins.
        cfg(5'd1);
        tick();
        pulse(16'h5001, fwd);
        bus.filt_valid  = 1'b1;
        bus.filt_sample = 16'h5002;
        bus.cfg_valid   = 1'b1;
        bus.cfg_stages  = 5'd6;
        tick();
        bus.filt_valid = 1'b0;
        bus.cfg_valid  = 1'b0;
        chk("coincide_settled", 32'(bus.settled), 32'h0);
        tick();
        chk("coincide_mask", 32'(bus.stage_enable), 32'h3F);

        // Randomized traffic against the model.
        for (int c = 0; c < 3000; c++) begin
            rst             = ($urandom_range(0, 399) == 0);
            bus.cfg_valid   = ($urandom_range(0, 49) == 0);
            bus.cfg_stages  = ($urandom_range(0, 9) == 0) ? 5'($urandom_range(0, 31))
                                                          : 5'($urandom_range(0, 8));
            bus.filt_valid  = 1'($urandom_range(0, 1));
            bus.filt_sample = 16'($urandom);
            tick();
        end
        rst = 1'b0;
        bus.cfg_valid  = 1'b0;
        bus.filt_valid = 1'b0;
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/lpf_stage_sequencer.md
Name: lpf_stage_sequencer

Overview:
Controls the stage_enable vector of the cascaded 2-sample low-pass filter chain used by the lock-in amplifier (LIA), based on a requested stage count from the register bank.
- The request is converted to a thermometer enable mask.
- After every change, the filter output is blanked for a settling window while the chain refills.
- Downstream (PID / lock logic) sees only settled samples: during settling it gets the last good value, held, with no valid strobes.

Parameters:
- num_stages, 8, number of filter stages in the controlled chain (1..16).
- settle_per_stage, 2, filter-output valid strobes to wait per enabled stage.
- cnt_width, 8, width of the settle counter; must hold num_stages*settle_per_stage.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset; synchronous, active-high.
- cfg_stages  in  5  requested number of enabled stages (0..num_stages).
- cfg_valid  in  1  one-cycle strobe; cfg_stages is sampled on this cycle.
- stage_enable  out  num_stages  to filter stage_enable; thermometer mask, bit i=1 when i < applied count.
- filt_sample  in  word_width  filter sample_out.
- filt_valid  in  1  filter sample_out_valid.
- sample_out  out  word_width  gated/held sample to downstream.
- sample_out_valid  out  1  gated valid strobe.
- settled  out  1  1 when in RUN.
- cfg_clamped  out  1  sticky; set when a request exceeded num_stages.

Behaviour:
- word_width comes from opo_package.
- Reset values: state=RUN, applied=0, stage_enable=0 (all stages pass through), sample_out=0, sample_out_valid=0, settled=1, cfg_clamped=0, counter=0.
- Reset mid-SETTLE returns to these same values.
- States: RUN, APPLY, SETTLE.
- cfg_valid handling (any state):
  - Target = min(cfg_stages, num_stages).
  - If cfg_stages > num_stages, cfg_clamped <= 1. It clears only on rst.
  - If in RUN and target == applied: no action; stay settled, no blanking.
  - Otherwise: latch target, state <= APPLY, settled <= 0 on the next edge.
- APPLY (exactly 1 cycle):
  - stage_enable <= thermometer(target); applied <= target.
  - Counter <= max(target,1)*settle_per_stage.
  - Next state: SETTLE.
- SETTLE:
  - Each filt_valid decrements the counter.
  - When filt_valid arrives with counter==1: state <= RUN, settled <= 1.
  - That strobe is NOT forwarded. The first forwarded sample is the next filt_valid in RUN.
- cfg_valid during APPLY or SETTLE restarts the sequence with the new target. It takes priority over a simultaneous final-count strobe.
- RUN forwarding:
  - On filt_valid: sample_out <= filt_sample, sample_out_valid <= 1 (1-cycle registered latency).
  - Otherwise sample_out_valid <= 0 and sample_out holds its value.
- APPLY and SETTLE: sample_out_valid=0; sample_out holds the last RUN value.
- stage_enable changes only in APPLY, and only one cycle after the accepting cfg_valid.
- The counter never underflows: filt_valid with counter==0 is impossible by construction; assert in simulation.

Decomposition:
- opo_package: add typedef lpf_seq_state_t (RUN, APPLY, SETTLE).
- opo_package: add function thermometer_mask(count, width).
- No sub-module: FSM, counter and output register live in one module.
- Integration: instantiate alongside the filter chain in the LIA path, with filt_* wired to the chain outputs.

Test Plan:
(num_stages=8, settle_per_stage=2, unless noted)
- Reset → stage_enable=8'h00, settled=1, sample_out=0. Then filt_valid with 16'h1234 → sample_out=16'h1234, valid exactly 1 cycle later.
- cfg_stages=3 strobe → stage_enable=8'h07 two cycles later, settled=0. The first 6 filt_valid strobes are dropped with sample_out held; the 7th is forwarded and settled=1.
- In RUN with applied=3, cfg_stages=3 strobe → no blanking: the next filt_valid is forwarded, settled stays 1.
- cfg_stages=20 → stage_enable=8'hFF, cfg_clamped=1, settle window of 16 strobes. cfg_clamped stays 1 after later valid configs and clears on rst.
- cfg_stages=2, then after 2 strobes cfg_stages=5 → stage_enable=8'h1F, counter restarts at 10. No samples forwarded until the 11th strobe.
- rst asserted mid-SETTLE → next cycle stage_enable=0, settled=1, sample_out=0. cfg_valid coinciding with the final settle strobe → the new config wins and settled stays 0.
